// File: rtl/operand_skid16_pkg.sv
// operand_skid16_pkg: shared width default and occupancy encodings
package operand_skid16_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_FULL  = 2'd2
  } lvl_e;
endpackage

// File: rtl/operand_skid16_pair_reg16.sv
// pair_reg16: two-operand register with load enable and sync active-low clear
module pair_reg16 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q0 <= '0;
      q1 <= '0;
    end else if (ld) begin
      q0 <= d0;
      q1 <= d1;
    end
  end
endmodule

// File: rtl/operand_skid16.sv
// operand_skid16: two-entry valid/ready skid buffer for a 16-bit operand pair
module operand_skid16
  import operand_skid16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] in0_16b,
  input  logic [WIDTH-1:0] in1_16b,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] out0_16b,
  output logic [WIDTH-1:0] out1_16b,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] xfer_cnt
);
  logic             sk_valid;
  logic [WIDTH-1:0] sk0;
  logic [WIDTH-1:0] sk1;
  logic             acc;
  logic             dq;
  logic             adv;
  logic             main_ld;
  logic             skid_ld;
  logic [WIDTH-1:0] main_d0;
  logic [WIDTH-1:0] main_d1;
  always_comb begin
    s_ready = !sk_valid;
    acc     = s_valid & s_ready;
    dq      = m_valid & m_ready;
    adv     = !m_valid | dq;
    main_ld = adv & (sk_valid | acc);
    skid_ld = acc & (adv ? sk_valid : 1'b1);
    main_d0 = sk_valid ? sk0 : in0_16b;
    main_d1 = sk_valid ? sk1 : in1_16b;
    level   = sk_valid ? LVL_FULL : (m_valid ? LVL_ONE : LVL_EMPTY);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      sk_valid <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      m_valid  <= adv ? (sk_valid | acc) : m_valid;
      sk_valid <= adv ? (sk_valid & acc) : (sk_valid | acc);
      xfer_cnt <= xfer_cnt + CNT_W'(dq);
    end
  end
  pair_reg16 #(.W(WIDTH)) u_main (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (main_ld),
    .d0   (main_d0),
    .d1   (main_d1),
    .q0   (out0_16b),
    .q1   (out1_16b)
  );
  pair_reg16 #(.W(WIDTH)) u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (skid_ld),
    .d0   (in0_16b),
    .d1   (in1_16b),
    .q0   (sk0),
    .q1   (sk1)
  );
endmodule

// File: tb/tb_operand_skid16.sv
// tb_operand_skid16: randomized queue-model check of operand_skid16
module tb_operand_skid16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] in0_16b = '0;
  logic [15:0] in1_16b = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] out0_16b;
  logic [15:0] out1_16b;
  logic [1:0]  level;
  logic [15:0] xfer_cnt;
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  logic [31:0] q[$];
  logic [31:0] last = '0;
  logic [15:0] mcnt = '0;
  operand_skid16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .in0_16b (in0_16b),
    .in1_16b (in1_16b),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .out0_16b(out0_16b),
    .out1_16b(out1_16b),
    .level   (level),
    .xfer_cnt(xfer_cnt)
  );
  always #5 clk = ~clk;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endfunction
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] front;
      front = (q.size() > 0) ? q[0] : last;
      chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
      chk("s_ready", 32'(s_ready), 32'(q.size() < 2));
      chk("level", 32'(level), 32'(q.size()));
      chk("out0", 32'(out0_16b), 32'(front[31:16]));
      chk("out1", 32'(out1_16b), 32'(front[15:0]));
      chk("xfer_cnt", 32'(xfer_cnt), 32'(mcnt));
    end
  end
  task automatic cyc(input logic rn, input logic sv, input logic [15:0] a, input logic [15:0] b, input logic mr);
    bit acc;
    bit dq;
    rst_n = rn;
    s_valid = sv;
    in0_16b = a;
    in1_16b = b;
    m_ready = mr;
    dq = (q.size() > 0) && mr;
    acc = sv && (q.size() < 2);
    if (rn && dq && chk_en)
      chk("or16", 32'(out0_16b | out1_16b), 32'(q[0][31:16] | q[0][15:0]));
    @(posedge clk);
    if (!rn) begin
      q.delete();
      last = '0;
      mcnt = '0;
    end else begin
      if (dq) begin
        last = q.pop_front();
        mcnt = mcnt + 16'd1;
      end
      if (acc) q.push_back({a, b});
    end
    @(negedge clk);
  endtask
  initial begin
    cyc(0, 0, 16'h0, 16'h0, 0);
    chk_en = 1'b1;
    cyc(0, 0, 16'h0, 16'h0, 0);
    cyc(1, 0, 16'h0, 16'h0, 0);
    chk("rst m_valid", 32'(m_valid), 0);
    chk("rst s_ready", 32'(s_ready), 1);
    chk("rst level", 32'(level), 0);
    chk("rst out0", 32'(out0_16b), 0);
    chk("rst xfer", 32'(xfer_cnt), 0);
    cyc(1, 1, 16'h00F0, 16'h0F00, 1);
    chk("single m_valid", 32'(m_valid), 1);
    chk("single out0", 32'(out0_16b), 32'h00F0);
    chk("single out1", 32'(out1_16b), 32'h0F00);
    cyc(1, 0, 16'h0, 16'h0, 1);
    chk("single xfer", 32'(xfer_cnt), 1);
    chk("single level", 32'(level), 0);
    cyc(1, 1, 16'h1111, 16'h2222, 0);
    cyc(1, 1, 16'h3333, 16'h4444, 0);
    chk("bp level", 32'(level), 2);
    chk("bp s_ready", 32'(s_ready), 0);
    chk("bp out0 A", 32'(out0_16b), 32'h1111);
    cyc(1, 1, 16'h5555, 16'h6666, 0);
    chk("bp C refused", 32'(level), 2);
    chk("bp hold out1", 32'(out1_16b), 32'h2222);
    cyc(1, 1, 16'h5555, 16'h6666, 1);
    chk("bp out0 B", 32'(out0_16b), 32'h3333);
    cyc(1, 1, 16'h5555, 16'h6666, 1);
    chk("bp out0 C", 32'(out0_16b), 32'h5555);
    chk("bp out1 C", 32'(out1_16b), 32'h6666);
    cyc(1, 0, 16'h0, 16'h0, 1);
    chk("bp xfer", 32'(xfer_cnt), 4);
    for (int i = 0; i < 100; i++) begin
      cyc(1, 1, 16'(i), ~16'(i), 1);
      chk("stream no bubble", 32'(m_valid), 1);
    end
    chk("stream xfer", 32'(xfer_cnt), 103);
    chk("stream last", 32'(out0_16b), 99);
    cyc(1, 0, 16'h0, 16'h0, 1);
    for (int i = 0; i < 10000; i++)
      cyc(1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    for (int i = 0; i < 4; i++) cyc(1, 0, 16'h0, 16'h0, 1);
    for (int i = 0; i < 70000 && mcnt != 16'hFFFF; i++)
      cyc(1, 1, 16'($urandom), 16'($urandom), 1);
    chk("wrap pre", 32'(xfer_cnt), 32'hFFFF);
    cyc(1, 0, 16'h0, 16'h0, 1);
    chk("wrap post", 32'(xfer_cnt), 0);
    cyc(1, 1, 16'hAAAA, 16'hBBBB, 0);
    cyc(1, 1, 16'hCCCC, 16'hDDDD, 0);
    chk("mid level full", 32'(level), 2);
    cyc(0, 1, 16'hEEEE, 16'hFFFF, 1);
    chk("mid rst level", 32'(level), 0);
    chk("mid rst m_valid", 32'(m_valid), 0);
    chk("mid rst xfer", 32'(xfer_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 16'h0, 16'h0, 1);
      chk("mid rst no emit", 32'(m_valid), 0);
    end
    chk("mid rst xfer idle", 32'(xfer_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
